// File: rtl/hmc_arb_pkg.sv
// Shared types, HMC command encodings and helper functions for the HMC port arbiter.
package hmc_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  // Command encodings mirror hmc_def.vh.
  localparam logic [3:0] HMC_CMD_RD = 4'b0110;
  localparam logic [3:0] HMC_CMD_WR = 4'b1000;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = 32'(i + 1);
    end
    return result;
  endfunction

  // Index of the lowest set bit; 64 when the bitmap is empty.
  function automatic logic [6:0] lowest_set(input logic [63:0] bitmap);
    logic [6:0] result;
    result = 7'd64;
    for (int i = 63; i >= 0; i--) begin
      if (bitmap[i]) result = 7'(i);
    end
    return result;
  endfunction

endpackage

// File: rtl/hmc_tag_pool.sv
// HMC tag pool: free bitmap, lowest-free allocation, owner table, response routing
// and spurious-response detection.
module hmc_tag_pool
  import hmc_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int TAG_WIDTH  = 6,
  parameter int NUM_TAGS   = 32,
  parameter int DATA_WIDTH = 128,
  parameter int OWN_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_alloc,
  input  logic [OWN_W-1:0]      i_alloc_owner,
  output logic [TAG_WIDTH-1:0]  o_alloc_tag,
  input  logic                  i_rd_valid,
  input  logic [TAG_WIDTH-1:0]  i_rd_tag,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic [NUM_REQ-1:0]    o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic [TAG_WIDTH-1:0]  o_rsp_tag,
  output logic [TAG_WIDTH:0]    o_tags_free,
  output logic                  o_spurious_err
);

  localparam int POOL_W = 1 << TAG_WIDTH;
  // Bits at and above NUM_TAGS never become free, so they are never allocated.
  localparam logic [POOL_W-1:0]  FREE_INIT = {POOL_W{1'b1}} >> (POOL_W - NUM_TAGS);
  localparam logic [POOL_W-1:0]  ONE_POOL  = {{(POOL_W-1){1'b0}}, 1'b1};
  localparam logic [NUM_REQ-1:0] ONE_REQ   = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [POOL_W-1:0]     r_free;
  logic [OWN_W-1:0]      r_owner [POOL_W];
  logic [TAG_WIDTH:0]    r_tags_free;
  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [TAG_WIDTH-1:0]  r_rsp_tag;
  logic                  r_spurious;

  logic [POOL_W-1:0]     w_busy;
  logic [POOL_W-1:0]     w_alloc_mask;
  logic [POOL_W-1:0]     w_rel_mask;
  logic [POOL_W-1:0]     w_free_nxt;
  logic                  w_rd_hit;
  logic [TAG_WIDTH:0]    w_cnt_nxt;

  // Allocation choice, response hit test and next bitmap with its popcount.
  always_comb begin
    o_alloc_tag  = TAG_WIDTH'(lowest_set(64'(r_free)));
    w_busy       = ~r_free & FREE_INIT;
    w_rd_hit     = i_rd_valid && w_busy[i_rd_tag];
    w_alloc_mask = i_alloc  ? (ONE_POOL << o_alloc_tag) : '0;
    w_rel_mask   = w_rd_hit ? (ONE_POOL << i_rd_tag)    : '0;
    w_free_nxt   = (r_free & ~w_alloc_mask) | w_rel_mask;
    w_cnt_nxt    = '0;
    for (int i = 0; i < POOL_W; i++) begin
      w_cnt_nxt = w_cnt_nxt + {{TAG_WIDTH{1'b0}}, w_free_nxt[i]};
    end
  end

  // Pool state, owner table and the one-cycle response strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_free      <= FREE_INIT;
      r_tags_free <= (TAG_WIDTH+1)'(NUM_TAGS);
      for (int i = 0; i < POOL_W; i++) r_owner[i] <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_tag   <= '0;
      r_spurious  <= 1'b0;
    end else begin
      r_free      <= w_free_nxt;
      r_tags_free <= w_cnt_nxt;
      if (i_alloc) r_owner[o_alloc_tag] <= i_alloc_owner;
      r_rsp_valid <= w_rd_hit ? (ONE_REQ << r_owner[i_rd_tag]) : '0;
      if (w_rd_hit) begin
        r_rsp_data <= i_rd_data;
        r_rsp_tag  <= i_rd_tag;
      end
      if (i_rd_valid && !w_rd_hit) r_spurious <= 1'b1;
    end
  end

  assign o_rsp_valid    = r_rsp_valid;
  assign o_rsp_data     = r_rsp_data;
  assign o_rsp_tag      = r_rsp_tag;
  assign o_tags_free    = r_tags_free;
  assign o_spurious_err = r_spurious;

endmodule

// File: rtl/hmc_port_arbiter.sv
// Round-robin arbiter sharing one HMC command/write-data port between NUM_REQ requesters.
// Optional statistics outputs are built when HMC_ARB_STATS_EN is defined.
module hmc_port_arbiter
  import hmc_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int TAG_WIDTH  = 6,
  parameter int NUM_TAGS   = 32,
  parameter int ADDR_WIDTH = 34,
  parameter int SIZE_WIDTH = 4,
  parameter int DATA_WIDTH = 128
) (
  input  logic                          rx_clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*4-1:0]          req_cmd,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*SIZE_WIDTH-1:0] req_size,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wr_data,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [3:0]                    cmd,
  output logic [ADDR_WIDTH-1:0]         addr,
  output logic [SIZE_WIDTH-1:0]         size,
  output logic [TAG_WIDTH-1:0]          tag,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          wr_data_valid,
  input  logic                          wr_data_ready,
  input  logic [DATA_WIDTH-1:0]         rd_data,
  input  logic [TAG_WIDTH-1:0]          rd_data_tag,
  input  logic                          rd_data_valid,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [TAG_WIDTH-1:0]          rsp_tag,
  output logic [TAG_WIDTH:0]            tags_free,
  output logic                          spurious_err,
  output logic                          idle
`ifdef HMC_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         grant_count,
  output logic [TAG_WIDTH:0]            max_outstanding,
  output logic [31:0]                   stall_cycles
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;
  localparam logic [TAG_WIDTH:0] FULL_CNT = (TAG_WIDTH+1)'(NUM_TAGS);

  arb_state_e            r_state;
  logic [PTR_W-1:0]      r_ptr;
  logic                  r_cmd_valid;
  logic                  r_wr_valid;
  logic [3:0]            r_cmd;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [SIZE_WIDTH-1:0] r_size;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic [DATA_WIDTH-1:0] r_wr_data;

  logic                  w_found;
  logic [PTR_W-1:0]      w_idx;
  logic [PTR_W-1:0]      w_win;
  logic [PTR_W-1:0]      w_ptr_nxt;
  logic                  w_grant;
  logic                  w_cmd_done;
  logic                  w_wr_done;
  logic [3:0]            w_sel_cmd;
  logic [TAG_WIDTH-1:0]  w_alloc_tag;
  logic [TAG_WIDTH:0]    w_tags_free;

  // Round-robin winner search from the pointer, grant gating and winner field select.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end else begin
        w_found = w_found;
      end
    end
    w_grant   = (r_state == IDLE) && (w_tags_free != '0) && w_found;
    req_ready = '0;
    if (w_grant) begin
      req_ready[w_win] = 1'b1;
    end else begin
      req_ready = '0;
    end
    w_ptr_nxt  = PTR_W'((int'(w_win) + 1) % NUM_REQ);
    w_sel_cmd  = req_cmd[w_win*4 +: 4];
    w_cmd_done = !r_cmd_valid || cmd_ready;
    w_wr_done  = !r_wr_valid || wr_data_ready;
  end

  // Command FSM: latch the winner's fields at grant, hold them until both handshakes finish.
  always_ff @(posedge rx_clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_cmd_valid <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_cmd       <= 4'd0;
      r_addr      <= '0;
      r_size      <= '0;
      r_tag       <= '0;
      r_wr_data   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_cmd       <= w_sel_cmd;
            r_addr      <= req_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
            r_size      <= req_size[w_win*SIZE_WIDTH +: SIZE_WIDTH];
            r_wr_data   <= req_wr_data[w_win*DATA_WIDTH +: DATA_WIDTH];
            r_tag       <= w_alloc_tag;
            r_cmd_valid <= 1'b1;
            r_wr_valid  <= (w_sel_cmd == HMC_CMD_WR);
            r_ptr       <= w_ptr_nxt;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_cmd_valid && cmd_ready)    r_cmd_valid <= 1'b0;
          if (r_wr_valid && wr_data_ready) r_wr_valid  <= 1'b0;
          if (w_cmd_done && w_wr_done)     r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  hmc_tag_pool #(
    .NUM_REQ    (NUM_REQ),
    .TAG_WIDTH  (TAG_WIDTH),
    .NUM_TAGS   (NUM_TAGS),
    .DATA_WIDTH (DATA_WIDTH),
    .OWN_W      (PTR_W)
  ) u_tag_pool (
    .clk            (rx_clk),
    .rst            (rst),
    .i_alloc        (w_grant),
    .i_alloc_owner  (w_win),
    .o_alloc_tag    (w_alloc_tag),
    .i_rd_valid     (rd_data_valid),
    .i_rd_tag       (rd_data_tag),
    .i_rd_data      (rd_data),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_data     (rsp_data),
    .o_rsp_tag      (rsp_tag),
    .o_tags_free    (w_tags_free),
    .o_spurious_err (spurious_err)
  );

  assign cmd_valid     = r_cmd_valid;
  assign wr_data_valid = r_wr_valid;
  assign cmd           = r_cmd;
  assign addr          = r_addr;
  assign size          = r_size;
  assign tag           = r_tag;
  assign wr_data       = r_wr_data;
  assign tags_free     = w_tags_free;
  assign idle          = (r_state == IDLE) && (w_tags_free == FULL_CNT);

`ifdef HMC_ARB_STATS_EN
  logic [15:0]          r_grant_cnt [NUM_REQ];
  logic [TAG_WIDTH:0]   r_max_out;
  logic [31:0]          r_stall;
  logic [TAG_WIDTH:0]   w_in_use;

  assign w_in_use = FULL_CNT - w_tags_free;

  // Saturating per-requester grant counters, outstanding high-water mark and stall counter.
  always_ff @(posedge rx_clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) r_grant_cnt[i] <= 16'd0;
      r_max_out <= '0;
      r_stall   <= 32'd0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_grant && (w_win == PTR_W'(i)) && (r_grant_cnt[i] != 16'hFFFF))
          r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
      end
      if (w_in_use > r_max_out) r_max_out <= w_in_use;
      if ((|req_valid) && !w_grant && (r_stall != 32'hFFFF_FFFF)) r_stall <= r_stall + 32'd1;
    end
  end

  // Pack the counter array onto the flat output.
  always_comb begin
    grant_count = '0;
    for (int i = 0; i < NUM_REQ; i++) grant_count[i*16 +: 16] = r_grant_cnt[i];
  end

  assign max_outstanding = r_max_out;
  assign stall_cycles    = r_stall;
`endif

endmodule

// File: tb/tb_hmc_port_arbiter.sv
// Directed self-checking bench for hmc_port_arbiter (default configuration).
module tb_hmc_port_arbiter;
  import hmc_arb_pkg::*;

  localparam int NR = 4;
  localparam int TW = 6;
  localparam int AW = 34;
  localparam int SW = 4;
  localparam int DW = 128;

  logic              rx_clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*4-1:0]   req_cmd;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*SW-1:0]  req_size;
  logic [NR*DW-1:0]  req_wr_data;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd;
  logic [AW-1:0]     addr;
  logic [SW-1:0]     size;
  logic [TW-1:0]     tag;
  logic [DW-1:0]     wr_data;
  logic              wr_data_valid;
  logic              wr_data_ready;
  logic [DW-1:0]     rd_data;
  logic [TW-1:0]     rd_data_tag;
  logic              rd_data_valid;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic [TW-1:0]     rsp_tag;
  logic [TW:0]       tags_free;
  logic              spurious_err;
  logic              idle;
`ifdef HMC_ARB_STATS_EN
  logic [NR*16-1:0]  grant_count;
  logic [TW:0]       max_outstanding;
  logic [31:0]       stall_cycles;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 rx_clk = ~rx_clk;

  hmc_port_arbiter dut (
    .rx_clk(rx_clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_size(req_size), .req_wr_data(req_wr_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd), .addr(addr),
    .size(size), .tag(tag), .wr_data(wr_data), .wr_data_valid(wr_data_valid),
    .wr_data_ready(wr_data_ready), .rd_data(rd_data), .rd_data_tag(rd_data_tag),
    .rd_data_valid(rd_data_valid), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .tags_free(tags_free), .spurious_err(spurious_err),
    .idle(idle)
`ifdef HMC_ARB_STATS_EN
    , .grant_count(grant_count), .max_outstanding(max_outstanding),
    .stall_cycles(stall_cycles)
`endif
  );

  task automatic tick();
    @(posedge rx_clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] c, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_cmd[i*4 +: 4]      = c;
    req_addr[i*AW +: AW]   = a;
    req_size[i*SW +: SW]   = 4'd1;
    req_wr_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rd_data_valid = 1'b0;
    rd_data_tag = '0;
    rd_data = '0;
    cmd_ready = 1'b1;
    wr_data_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req_cmd = '0; req_addr = '0; req_size = '0; req_wr_data = '0;
    do_reset();
    n_checks++; if (cmd_valid !== 1'b0) begin n_errors++; $display("FAIL rst_cmd_valid got=%0b exp=0", cmd_valid); end
    n_checks++; if (wr_data_valid !== 1'b0) begin n_errors++; $display("FAIL rst_wr_valid got=%0b exp=0", wr_data_valid); end
    n_checks++; if (tag !== 6'd0 || addr !== 34'd0) begin n_errors++; $display("FAIL rst_fields tag=%0d addr=%0h exp=0", tag, addr); end
    n_checks++; if (rsp_valid !== 4'b0000) begin n_errors++; $display("FAIL rst_rsp_valid got=%b exp=0000", rsp_valid); end
    n_checks++; if (tags_free !== 7'd32) begin n_errors++; $display("FAIL rst_tags_free got=%0d exp=32", tags_free); end
    n_checks++; if (spurious_err !== 1'b0) begin n_errors++; $display("FAIL rst_spurious got=%0b exp=0", spurious_err); end
    n_checks++; if (idle !== 1'b1) begin n_errors++; $display("FAIL rst_idle got=%0b exp=1", idle); end
  endtask

  task automatic test_single_rd();
    do_reset();
    set_req(2, HMC_CMD_RD, 34'h100, 128'd0);
    req_valid = 4'b0100;
    #2;
    n_checks++; if (req_ready !== 4'b0100) begin n_errors++; $display("FAIL rd_req_ready got=%b exp=0100", req_ready); end
    tick();
    req_valid = 4'b0000;
    n_checks++; if (cmd_valid !== 1'b1 || wr_data_valid !== 1'b0) begin n_errors++; $display("FAIL rd_valids cmd=%0b wr=%0b exp=1,0", cmd_valid, wr_data_valid); end
    n_checks++; if (tag !== 6'd0 || addr !== 34'h100 || cmd !== HMC_CMD_RD) begin n_errors++; $display("FAIL rd_fields tag=%0d addr=%0h cmd=%0h exp=0,100,%0h", tag, addr, cmd, HMC_CMD_RD); end
    n_checks++; if (tags_free !== 7'd31) begin n_errors++; $display("FAIL rd_tags_alloc got=%0d exp=31", tags_free); end
    tick();
    n_checks++; if (cmd_valid !== 1'b0 || idle !== 1'b0) begin n_errors++; $display("FAIL rd_after_hs cmd_valid=%0b idle=%0b exp=0,0", cmd_valid, idle); end
    rd_data = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
    rd_data_tag = 6'd0;
    rd_data_valid = 1'b1;
    tick();
    rd_data_valid = 1'b0;
    n_checks++; if (rsp_valid !== 4'b0100) begin n_errors++; $display("FAIL rd_rsp_valid got=%b exp=0100", rsp_valid); end
    n_checks++; if (rsp_data !== 128'hA5A5_0000_1111_2222_3333_4444_5555_6666 || rsp_tag !== 6'd0) begin n_errors++; $display("FAIL rd_rsp_fields data=%h tag=%0d", rsp_data, rsp_tag); end
    n_checks++; if (tags_free !== 7'd32) begin n_errors++; $display("FAIL rd_tags_freed got=%0d exp=32", tags_free); end
    tick();
    n_checks++; if (rsp_valid !== 4'b0000 || idle !== 1'b1) begin n_errors++; $display("FAIL rd_rsp_pulse rsp_valid=%b idle=%0b exp=0000,1", rsp_valid, idle); end
  endtask

  task automatic test_round_robin();
    int budget;
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, HMC_CMD_RD, 34'h1000 + 34'(i * 16), 128'd0);
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      budget = 0;
      do begin tick(); budget++; end while (cmd_valid !== 1'b1 && budget < 10);
      n_checks++; if (cmd_valid !== 1'b1) begin n_errors++; $display("FAIL rr_timeout grant=%0d cmd_valid=%0b exp=1", g, cmd_valid); end
      n_checks++; if (tag !== 6'(g) || addr !== 34'h1000 + 34'((g % NR) * 16)) begin n_errors++; $display("FAIL rr_order grant=%0d tag=%0d addr=%0h exp tag=%0d req=%0d", g, tag, addr, g, g % NR); end
    end
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_wr_backpressure();
    do_reset();
    set_req(1, HMC_CMD_WR, 34'h200, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D);
    set_req(0, HMC_CMD_RD, 34'h300, 128'd0);
    wr_data_ready = 1'b0;
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0001;
    n_checks++; if (cmd_valid !== 1'b1 || wr_data_valid !== 1'b1 || cmd !== HMC_CMD_WR) begin n_errors++; $display("FAIL wr_issue cmd_valid=%0b wr_valid=%0b cmd=%0h", cmd_valid, wr_data_valid, cmd); end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++; if (cmd_valid !== 1'b0 || wr_data_valid !== 1'b1 || req_ready !== 4'b0000) begin n_errors++; $display("FAIL wr_hold cyc=%0d cmd_valid=%0b wr_valid=%0b req_ready=%b exp=0,1,0000", k, cmd_valid, wr_data_valid, req_ready); end
      n_checks++; if (wr_data !== 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D) begin n_errors++; $display("FAIL wr_stable cyc=%0d got=%h", k, wr_data); end
    end
    wr_data_ready = 1'b1;
    tick();
    n_checks++; if (wr_data_valid !== 1'b0 || req_ready !== 4'b0001) begin n_errors++; $display("FAIL wr_done wr_valid=%0b req_ready=%b exp=0,0001", wr_data_valid, req_ready); end
    tick();
    req_valid = 4'b0000;
    n_checks++; if (cmd_valid !== 1'b1 || tag !== 6'd1 || addr !== 34'h300) begin n_errors++; $display("FAIL wr_next_grant cmd_valid=%0b tag=%0d addr=%0h exp=1,1,300", cmd_valid, tag, addr); end
    tick();
  endtask

  task automatic test_pool_empty();
    int budget;
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, HMC_CMD_RD, 34'h400 + 34'(i * 16), 128'd0);
    req_valid = 4'b0001;
    budget = 0;
    while (tags_free !== 7'd0 && budget < 200) begin tick(); budget++; end
    n_checks++; if (tags_free !== 7'd0 || tag !== 6'd31) begin n_errors++; $display("FAIL empty_fill tags_free=%0d last_tag=%0d exp=0,31", tags_free, tag); end
    req_valid = 4'b1111;
    tick();
    tick();
    n_checks++; if (req_ready !== 4'b0000 || cmd_valid !== 1'b0) begin n_errors++; $display("FAIL empty_no_grant req_ready=%b cmd_valid=%0b exp=0000,0", req_ready, cmd_valid); end
    rd_data_tag = 6'd7;
    rd_data_valid = 1'b1;
    tick();
    rd_data_valid = 1'b0;
    n_checks++; if (rsp_valid !== 4'b0001 || tags_free !== 7'd1) begin n_errors++; $display("FAIL empty_free7 rsp_valid=%b tags_free=%0d exp=0001,1", rsp_valid, tags_free); end
    n_checks++; if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL empty_ready req_ready=%b exp=0010", req_ready); end
    tick();
    req_valid = 4'b0000;
    n_checks++; if (cmd_valid !== 1'b1 || tag !== 6'd7 || tags_free !== 7'd0) begin n_errors++; $display("FAIL empty_reuse7 cmd_valid=%0b tag=%0d tags_free=%0d exp=1,7,0", cmd_valid, tag, tags_free); end
    tick();
  endtask

  task automatic test_simultaneous();
    rd_data_tag = 6'd5;
    rd_data_valid = 1'b1;
    tick();
    rd_data_valid = 1'b0;
    n_checks++; if (tags_free !== 7'd1 || rsp_valid !== 4'b0001) begin n_errors++; $display("FAIL sim_free5 tags_free=%0d rsp_valid=%b exp=1,0001", tags_free, rsp_valid); end
    req_valid = 4'b0100;
    rd_data_tag = 6'd3;
    rd_data_valid = 1'b1;
    #2;
    n_checks++; if (req_ready !== 4'b0100) begin n_errors++; $display("FAIL sim_ready got=%b exp=0100", req_ready); end
    tick();
    rd_data_valid = 1'b0;
    n_checks++; if (cmd_valid !== 1'b1 || tag !== 6'd5 || tags_free !== 7'd1) begin n_errors++; $display("FAIL sim_grant cmd_valid=%0b tag=%0d tags_free=%0d exp=1,5,1", cmd_valid, tag, tags_free); end
    n_checks++; if (rsp_valid !== 4'b0001 || rsp_tag !== 6'd3) begin n_errors++; $display("FAIL sim_rsp rsp_valid=%b rsp_tag=%0d exp=0001,3", rsp_valid, rsp_tag); end
    tick();
    tick();
    req_valid = 4'b0000;
    n_checks++; if (cmd_valid !== 1'b1 || tag !== 6'd3 || tags_free !== 7'd0) begin n_errors++; $display("FAIL sim_reuse3 cmd_valid=%0b tag=%0d tags_free=%0d exp=1,3,0", cmd_valid, tag, tags_free); end
    tick();
  endtask

  task automatic test_spurious_and_reset();
    do_reset();
    rd_data_tag = 6'd20;
    rd_data_valid = 1'b1;
    tick();
    rd_data_valid = 1'b0;
    n_checks++; if (spurious_err !== 1'b1 || rsp_valid !== 4'b0000 || tags_free !== 7'd32) begin n_errors++; $display("FAIL spur_tag20 err=%0b rsp_valid=%b tags_free=%0d exp=1,0000,32", spurious_err, rsp_valid, tags_free); end
    tick();
    tick();
    n_checks++; if (spurious_err !== 1'b1) begin n_errors++; $display("FAIL spur_sticky got=%0b exp=1", spurious_err); end
    cmd_ready = 1'b0;
    set_req(0, HMC_CMD_RD, 34'h500, 128'd0);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    n_checks++; if (cmd_valid !== 1'b1 || tags_free !== 7'd31) begin n_errors++; $display("FAIL midrst_issue cmd_valid=%0b tags_free=%0d exp=1,31", cmd_valid, tags_free); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmd_ready = 1'b1;
    n_checks++; if (cmd_valid !== 1'b0 || tags_free !== 7'd32 || spurious_err !== 1'b0) begin n_errors++; $display("FAIL midrst_clear cmd_valid=%0b tags_free=%0d err=%0b exp=0,32,0", cmd_valid, tags_free, spurious_err); end
    rd_data_tag = 6'd0;
    rd_data_valid = 1'b1;
    tick();
    rd_data_valid = 1'b0;
    n_checks++; if (spurious_err !== 1'b1 || rsp_valid !== 4'b0000 || tags_free !== 7'd32) begin n_errors++; $display("FAIL midrst_forgot err=%0b rsp_valid=%b tags_free=%0d exp=1,0000,32", spurious_err, rsp_valid, tags_free); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_rd();
    test_round_robin();
    test_wr_backpressure();
    test_pool_empty();
    test_simultaneous();
    test_spurious_and_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
